// File: rtl/adc_ddr_emulator_if.sv
// Control, playback-buffer write and DDR output signals of adc_ddr_emulator.
// The host side attaches through master, the emulator through slave.
interface adc_ddr_emulator_if #(
   parameter int CHANNELS = 1,
   parameter int SAMPLE_W = 16,
   parameter int DEPTH    = 256
);
   localparam int LANES  = SAMPLE_W / 2;
   localparam int AW     = $clog2(DEPTH);
   localparam int DATA_W = CHANNELS * SAMPLE_W;
   localparam int NLANE  = CHANNELS * LANES;

   logic                en;
   logic [1:0]          mode;
   logic [SAMPLE_W-1:0] const_val;
   logic [SAMPLE_W-1:0] ramp_init;
   logic [AW:0]         len;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                outclk_p;
   logic                outclk_n;
   logic [NLANE-1:0]    d_p;
   logic [NLANE-1:0]    d_n;
   logic                busy;
   logic [31:0]         sample_cnt;
   logic                wrap;

   modport master (
      output en, mode, const_val, ramp_init, len, wr_en, wr_addr, wr_data,
      input  outclk_p, outclk_n, d_p, d_n, busy, sample_cnt, wrap
   );

   modport slave (
      input  en, mode, const_val, ramp_init, len, wr_en, wr_addr, wr_data,
      output outclk_p, outclk_n, d_p, d_n, busy, sample_cnt, wrap
   );
endinterface

// File: rtl/adc_ddr_emulator.sv
// Multi-channel DDR LVDS ADC output emulator: each sample is shifted out as
// odd bits then even bits over 4 clk ticks with a centre-aligned forwarded clock.
module adc_ddr_emulator #(
   parameter int CHANNELS = 1,
   parameter int SAMPLE_W = 16,
   parameter int DEPTH    = 256
) (
   input  logic              clk,
   input  logic              rst,
   adc_ddr_emulator_if.slave bus
);
   localparam int LANES  = SAMPLE_W / 2;
   localparam int AW     = $clog2(DEPTH);
   localparam int DATA_W = CHANNELS * SAMPLE_W;
   localparam int NLANE  = CHANNELS * LANES;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, PRIME, LOAD, RUN} state_e;
   typedef enum logic [1:0] {MODE_ZERO, MODE_RAMP, MODE_CONST, MODE_PLAY} mode_e;

   state_e              state_q, state_d;
   logic [1:0]          tick_q, tick_d;
   mode_e               mode_q, mode_d;
   logic [AW:0]         len_q, len_d;
   logic [SAMPLE_W-1:0] const_q, const_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [SAMPLE_W-1:0] ramp_q, ramp_d;
   logic [DATA_W-1:0]   w_q, w_d;
   logic                outclk_q, outclk_d;
   logic                outclk_n_q;
   logic [NLANE-1:0]    d_p_q, d_p_d, d_n_q;
   logic                busy_q;
   logic [31:0]         cnt_q, cnt_d;
   logic                wrap_q, wrap_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   rd_q;
   logic                rd_en;
   logic [AW-1:0]       rd_addr;

   logic [AW:0]         len_eff;
   logic [AW-1:0]       addr_nxt;

   function automatic logic [DATA_W-1:0] make_sample(
      input mode_e               sel,
      input logic [SAMPLE_W-1:0] ramp,
      input logic [SAMPLE_W-1:0] cval,
      input logic [DATA_W-1:0]   pb
   );
      logic [DATA_W-1:0] s;
      s = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         case (sel)
            MODE_RAMP:  s[c*SAMPLE_W +: SAMPLE_W] = ramp + SAMPLE_W'(c);
            MODE_CONST: s[c*SAMPLE_W +: SAMPLE_W] = cval;
            MODE_PLAY:  s[c*SAMPLE_W +: SAMPLE_W] = pb[c*SAMPLE_W +: SAMPLE_W];
            default:    s[c*SAMPLE_W +: SAMPLE_W] = '0;
         endcase
      end
      return s;
   endfunction

   // Lane c*LANES+k carries bit 2k+1 (odd phase) or bit 2k (even phase) of channel c.
   function automatic logic [NLANE-1:0] pick_lanes(
      input logic [DATA_W-1:0] s,
      input logic              odd
   );
      logic [NLANE-1:0] l;
      l = '0;
      for (int c = 0; c < CHANNELS; c++)
         for (int k = 0; k < LANES; k++)
            l[c*LANES + k] = s[c*SAMPLE_W + 2*k + (odd ? 1 : 0)];
      return l;
   endfunction

   assign len_eff  = (len_q == '0 || len_q > DEPTH_L) ? DEPTH_L : len_q;
   assign addr_nxt = (({1'b0, addr_q} + (AW+1)'(1)) == len_eff) ? '0 : addr_q + 1'b1;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_d  = state_q;
      tick_d   = tick_q;
      mode_d   = mode_q;
      len_d    = len_q;
      const_d  = const_q;
      addr_d   = addr_q;
      ramp_d   = ramp_q;
      w_d      = w_q;
      outclk_d = outclk_q;
      d_p_d    = d_p_q;
      cnt_d    = cnt_q;
      wrap_d   = 1'b0;
      rd_en    = 1'b0;
      rd_addr  = addr_nxt;

      case (state_q)
         IDLE: begin
            outclk_d = 1'b1;
            d_p_d    = '0;
            if (bus.en) begin
               state_d = PRIME;
               mode_d  = mode_e'(bus.mode);
               len_d   = bus.len;
               const_d = bus.const_val;
               ramp_d  = bus.ramp_init;
               addr_d  = '0;
               cnt_d   = '0;
            end
         end
         PRIME: begin
            rd_en   = 1'b1;
            rd_addr = '0;
            state_d = LOAD;
         end
         LOAD: begin
            w_d     = make_sample(mode_q, ramp_q, const_q, rd_q);
            tick_d  = 2'd0;
            state_d = RUN;
         end
         RUN: begin
            tick_d = tick_q + 2'd1;
            case (tick_q)
               2'd0: d_p_d = pick_lanes(w_q, 1'b1);
               2'd1: begin
                  outclk_d = 1'b0;
                  rd_en    = 1'b1;
               end
               2'd2: d_p_d = pick_lanes(w_q, 1'b0);
               default: begin
                  outclk_d = 1'b1;
                  cnt_d    = cnt_q + 32'd1;
                  if (!bus.en) begin
                     state_d = IDLE;
                     d_p_d   = '0;
                  end else begin
                     // Mode, constant and length take effect only at this sample boundary.
                     mode_d  = mode_e'(bus.mode);
                     len_d   = bus.len;
                     const_d = bus.const_val;
                     addr_d  = addr_nxt;
                     ramp_d  = ramp_q + 1'b1;
                     w_d     = make_sample(mode_e'(bus.mode), ramp_d, bus.const_val, rd_q);
                     wrap_d  = (addr_nxt == '0) && (mode_e'(bus.mode) == MODE_PLAY);
                  end
               end
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         tick_q     <= '0;
         mode_q     <= MODE_ZERO;
         len_q      <= '0;
         const_q    <= '0;
         addr_q     <= '0;
         ramp_q     <= '0;
         w_q        <= '0;
         outclk_q   <= 1'b1;
         outclk_n_q <= 1'b0;
         d_p_q      <= '0;
         d_n_q      <= '1;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         mode_q     <= mode_d;
         len_q      <= len_d;
         const_q    <= const_d;
         addr_q     <= addr_d;
         ramp_q     <= ramp_d;
         w_q        <= w_d;
         outclk_q   <= outclk_d;
         outclk_n_q <= ~outclk_d;
         d_p_q      <= d_p_d;
         d_n_q      <= ~d_p_d;
         busy_q     <= (state_d != IDLE);
         cnt_q      <= cnt_d;
         wrap_q     <= wrap_d;
      end
   end

   // NOTE: the playback RAM has no reset so it maps onto block RAM and survives rst.
   always_ff @(posedge clk) begin
      if (bus.wr_en)
         mem_q[bus.wr_addr] <= bus.wr_data;
      if (rd_en)
         rd_q <= mem_q[rd_addr];
   end

   assign bus.outclk_p   = outclk_q;
   assign bus.outclk_n   = outclk_n_q;
   assign bus.d_p        = d_p_q;
   assign bus.d_n        = d_n_q;
   assign bus.busy       = busy_q;
   assign bus.sample_cnt = cnt_q;
   assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_adc_ddr_emulator.sv
// Directed bench for adc_ddr_emulator: 2 channels x 16 bits, 8-entry buffer;
// DDR lanes are reassembled into samples and compared with hand-computed values.
module tb_adc_ddr_emulator;
   localparam int CH  = 2;
   localparam int SW  = 16;
   localparam int DEP = 8;
   localparam int NL  = CH * SW / 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   wrap_seen = 0;
   logic [31:0] mem_model [DEP];

   adc_ddr_emulator_if #(.CHANNELS(CH), .SAMPLE_W(SW), .DEPTH(DEP)) bus ();

   adc_ddr_emulator #(.CHANNELS(CH), .SAMPLE_W(SW), .DEPTH(DEP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (bus.wrap === 1'b1) wrap_seen++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic write_buf(input logic [2:0] a, input logic [31:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   // Waits for outclk to fall, grabs odd then even lanes, then steps past the
   // rising edge; with last set, en is dropped so the emulator stops there.
   task automatic get_sample(input bit last, output logic [31:0] w);
      logic [NL-1:0] odd, even;
      int guard;
      guard = 0;
      w = '0;
      while (bus.outclk_p !== 1'b0 && guard < 16) begin
         tick();
         guard++;
      end
      if (guard >= 16) check("outclk_fall_timeout", 64'(bus.outclk_p), 64'd0);
      odd = bus.d_p;
      tick();
      even = bus.d_p;
      check("outclk_low_2nd_cycle", 64'(bus.outclk_p), 64'd0);
      if (last) bus.en = 1'b0;
      tick();
      check("outclk_rise", 64'(bus.outclk_p), 64'd1);
      for (int c = 0; c < CH; c++)
         for (int k = 0; k < SW/2; k++) begin
            w[c*SW + 2*k + 1] = odd[c*(SW/2) + k];
            w[c*SW + 2*k]     = even[c*(SW/2) + k];
         end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_outclk_p"}, 64'(bus.outclk_p), 64'd1);
      check({tag, "_outclk_n"}, 64'(bus.outclk_n), 64'd0);
      check({tag, "_d_p"},      64'(bus.d_p),      64'h0);
      check({tag, "_d_n"},      64'(bus.d_n),      64'hFFFF);
      check({tag, "_busy"},     64'(bus.busy),     64'd0);
   endtask

   initial begin
      logic [31:0] w;
      logic [15:0] e0, e1;
      int wrap_base;

      bus.en = 1'b0; bus.mode = 2'd0; bus.const_val = '0; bus.ramp_init = '0;
      bus.len = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

      repeat (3) tick();
      check_idle("reset");
      check("reset_cnt",  64'(bus.sample_cnt), 64'd0);
      check("reset_wrap", 64'(bus.wrap),       64'd0);
      rst = 1'b0;
      tick();

      // Constant A5C3: odd bits b15..b1 = 1100_1001, even bits b14..b0 = 0011_1001.
      bus.mode = 2'd2; bus.const_val = 16'hA5C3; bus.en = 1'b1;
      tick();
      check("e0_busy",   64'(bus.busy),     64'd1);
      check("e0_d_p",    64'(bus.d_p),      64'h0);
      tick(); tick();
      check("e2_d_p",    64'(bus.d_p),      64'h0);
      check("e2_outclk", 64'(bus.outclk_p), 64'd1);
      tick();
      check("e3_odd",    64'(bus.d_p),      64'hC9C9);
      check("e3_d_n",    64'(bus.d_n),      64'h3636);
      check("e3_outclk", 64'(bus.outclk_p), 64'd1);
      tick();
      check("e4_outclk", 64'(bus.outclk_p), 64'd0);
      check("e4_odd",    64'(bus.d_p),      64'hC9C9);
      tick();
      check("e5_even",   64'(bus.d_p),      64'h3939);
      check("e5_outclk", 64'(bus.outclk_p), 64'd0);
      tick();
      check("e6_outclk", 64'(bus.outclk_p), 64'd1);
      check("e6_even",   64'(bus.d_p),      64'h3939);
      check("e6_cnt",    64'(bus.sample_cnt), 64'd1);
      tick();
      check("e7_odd",    64'(bus.d_p),      64'hC9C9);
      get_sample(1'b0, w);
      check("const_s2",  64'(w),            64'hA5C3A5C3);

      // Asynchronous reset while outclk is low.
      tick(); tick();
      check("pre_rst_outclk", 64'(bus.outclk_p), 64'd0);
      #2 rst = 1'b1; bus.en = 1'b0;
      #1;
      check_idle("async_rst");
      check("async_rst_cnt", 64'(bus.sample_cnt), 64'd0);
      #3 rst = 1'b0;
      repeat (3) tick();
      check_idle("post_rst");

      // Ramp across the 16-bit wrap; en drops at t=1 of sample 5.
      bus.mode = 2'd1; bus.ramp_init = 16'hFFFE; bus.en = 1'b1;
      for (int j = 0; j < 5; j++) begin
         get_sample(1'b0, w);
         e0 = 16'hFFFE + 16'(j);
         e1 = 16'hFFFF + 16'(j);
         check($sformatf("ramp_ch0_s%0d", j), 64'(w[15:0]),  64'(e0));
         check($sformatf("ramp_ch1_s%0d", j), 64'(w[31:16]), 64'(e1));
         if (j == 3) check("ramp_cnt4", 64'(bus.sample_cnt), 64'd4);
      end
      tick();
      bus.en = 1'b0;
      get_sample(1'b0, w);
      check("ramp_s5",       64'(w),              64'h00040003);
      check_idle("en_drop");
      check("en_drop_cnt",   64'(bus.sample_cnt), 64'd6);

      // Load the playback buffer while idle.
      for (int i = 0; i < DEP; i++) begin
         mem_model[i] = {~(16'h1111 * 16'(i + 1)), 16'h1111 * 16'(i + 1)};
         write_buf(3'(i), mem_model[i]);
      end

      // len = 3, with a colliding write to address 1 while address 0 plays.
      wrap_base = wrap_seen;
      bus.mode = 2'd3; bus.len = 4'd3; bus.en = 1'b1;
      for (int j = 0; j < 8; j++) begin
         if (j == 3) begin
            tick();
            bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 32'h5A5A5555;
            tick();
            bus.wr_en = 1'b0;
         end
         get_sample(j == 7, w);
         check($sformatf("play3_s%0d", j), 64'(w), 64'(mem_model[j % 3]));
         if (j == 4) mem_model[1] = 32'h5A5A5555;
      end
      check("play3_wraps", 64'(wrap_seen - wrap_base), 64'd2);
      check("play3_cnt",   64'(bus.sample_cnt),        64'd8);
      check("play3_busy",  64'(bus.busy),              64'd0);
      tick();

      // len = 0 plays all DEPTH entries, then wraps to address 0.
      wrap_base = wrap_seen;
      bus.len = 4'd0; bus.en = 1'b1;
      for (int j = 0; j < DEP + 1; j++) begin
         get_sample(j == DEP, w);
         check($sformatf("play0_s%0d", j), 64'(w), 64'(mem_model[j % DEP]));
      end
      check("play0_wraps", 64'(wrap_seen - wrap_base), 64'd1);
      check("play0_cnt",   64'(bus.sample_cnt),        64'd9);
      check_idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
